// File: rtl/core_ram_io_seq.sv
`default_nettype none
// ============================================================================
//  Module      : core_ram_io_seq
//  Description : Host-side load/readback sequencer for the pairing core's
//                wide operand RAM. Packs NUM_LANES host words into one RAM
//                line and writes it in a single cycle. Reads one line after
//                a fixed latency and streams it back lane by lane.
//  Ports       : clk, rst_n (sync, active-low)
//                s_cmd_*     command stream (op 0 = write, 1 = read, addr)
//                s_w*        write word stream, lane 0 first
//                m_r*        readback word stream with last flag
//                core_w*     core RAM write port (one-cycle wen pulse)
//                core_r*     core RAM read port
//                core_busy   core computation in progress
//  Options     : CORE_RAM_IO_BUSY_GUARD_EN - hold off commands and the RAM
//                write while core_busy is high (port is ignored otherwise)
//  Revision    : 1.0 - initial release
// ============================================================================
module core_ram_io_seq #(
   parameter int WORD_SIZE    = 16,
   parameter int NUM_LANES    = 24,
   parameter int ADDR_SIZE    = 8,
   parameter int READ_LATENCY = 2
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           s_cmd_valid,
   output logic                           s_cmd_ready,
   input  logic                           s_cmd_op,
   input  logic [ADDR_SIZE-1:0]           s_cmd_addr,
   input  logic                           s_wvalid,
   output logic                           s_wready,
   input  logic [WORD_SIZE-1:0]           s_wdata,
   output logic                           m_rvalid,
   input  logic                           m_rready,
   output logic [WORD_SIZE-1:0]           m_rdata,
   output logic                           m_rlast,
   output logic                           core_wen,
   output logic [ADDR_SIZE-1:0]           core_waddr,
   output logic [NUM_LANES*WORD_SIZE-1:0] core_wdata,
   output logic [ADDR_SIZE-1:0]           core_raddr,
   input  logic [NUM_LANES*WORD_SIZE-1:0] core_rdata,
   input  logic                           core_busy
);

   localparam int c_cnt_w  = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
   localparam int c_wait_w = $clog2(READ_LATENCY + 1);

   localparam logic [c_cnt_w-1:0]  c_last_lane = c_cnt_w'(NUM_LANES - 1);
   localparam logic [c_wait_w-1:0] c_read_lat  = c_wait_w'(READ_LATENCY);

   localparam logic [2:0] c_st_idle  = 3'd0;
   localparam logic [2:0] c_st_fill  = 3'd1;
   localparam logic [2:0] c_st_write = 3'd2;
   localparam logic [2:0] c_st_rwait = 3'd3;
   localparam logic [2:0] c_st_drain = 3'd4;

   logic [2:0]            r_state;
   logic [c_cnt_w-1:0]    r_cnt;
   logic [c_wait_w-1:0]   r_wait;
   logic [WORD_SIZE-1:0]  r_lane [NUM_LANES];
   logic [ADDR_SIZE-1:0]  r_waddr;
   logic [ADDR_SIZE-1:0]  r_raddr;
   // Low during reset and for the first edge after it, so s_cmd_ready
   // stays 0 while rst_n is asserted even though the state is already IDLE.
   logic                  r_out_en;

   logic w_busy_ok;
   logic w_cmd_fire;
   logic w_word_fire;
   logic w_rd_fire;
   logic w_last;

`ifdef CORE_RAM_IO_BUSY_GUARD_EN
   assign w_busy_ok = ~core_busy;
`else
   logic w_unused_busy;
   assign w_unused_busy = core_busy;
   assign w_busy_ok     = 1'b1;
`endif

   assign s_cmd_ready = r_out_en && (r_state == c_st_idle) && w_busy_ok;
   assign s_wready    = (r_state == c_st_fill);
   assign m_rvalid    = (r_state == c_st_drain);
   assign core_wen    = (r_state == c_st_write) && w_busy_ok;
   assign core_waddr  = r_waddr;
   assign core_raddr  = r_raddr;

   assign w_cmd_fire  = s_cmd_valid && s_cmd_ready;
   assign w_word_fire = s_wvalid && s_wready;
   assign w_rd_fire   = m_rvalid && m_rready;
   assign w_last      = (r_cnt == c_last_lane);

   // Outputs depend only on registered state, so they cannot change while
   // m_rvalid is high and m_rready is low.
   assign m_rlast = m_rvalid && w_last;
   assign m_rdata = m_rvalid ? r_lane[r_cnt] : '0;

   generate
      for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_pack
         assign core_wdata[gi*WORD_SIZE +: WORD_SIZE] = r_lane[gi];
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state  <= c_st_idle;
         r_cnt    <= '0;
         r_wait   <= '0;
         r_waddr  <= '0;
         r_raddr  <= '0;
         r_out_en <= 1'b0;
         for (int i = 0; i < NUM_LANES; i++) begin
            r_lane[i] <= '0;
         end
      end else begin
         r_out_en <= 1'b1;
         case (r_state)
            c_st_idle: begin
               if (w_cmd_fire) begin
                  if (s_cmd_op) begin
                     r_raddr <= s_cmd_addr;
                     r_wait  <= '0;
                     r_state <= c_st_rwait;
                  end else begin
                     r_waddr <= s_cmd_addr;
                     r_cnt   <= '0;
                     r_state <= c_st_fill;
                  end
               end
            end
            c_st_fill: begin
               if (w_word_fire) begin
                  r_lane[r_cnt] <= s_wdata;
                  if (w_last) begin
                     r_cnt   <= '0;
                     r_state <= c_st_write;
                  end else begin
                     r_cnt <= r_cnt + 1'b1;
                  end
               end
            end
            c_st_write: begin
               if (core_wen) begin
                  r_state <= c_st_idle;
               end
            end
            c_st_rwait: begin
               // Wait value k is seen in cycle k after raddr became valid,
               // so capture happens exactly READ_LATENCY cycles later.
               if (r_wait == c_read_lat) begin
                  for (int i = 0; i < NUM_LANES; i++) begin
                     r_lane[i] <= core_rdata[i*WORD_SIZE +: WORD_SIZE];
                  end
                  r_cnt   <= '0;
                  r_state <= c_st_drain;
               end else begin
                  r_wait <= r_wait + 1'b1;
               end
            end
            c_st_drain: begin
               if (w_rd_fire) begin
                  if (w_last) begin
                     r_cnt   <= '0;
                     r_state <= c_st_idle;
                  end else begin
                     r_cnt <= r_cnt + 1'b1;
                  end
               end
            end
            default: begin
               r_state <= c_st_idle;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_core_ram_io_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_core_ram_io_seq
//  Description : Self-checking bench for core_ram_io_seq with a latency-exact
//                RAM model and a scoreboard of expected RAM writes and
//                readback words.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_core_ram_io_seq;

   localparam int WS = 16;
   localparam int NL = 24;
   localparam int AS = 8;
   localparam int RL = 2;
   localparam int LW = NL * WS;
   localparam logic [LW-1:0] JUNK = {NL{16'hDEAD}};

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          s_cmd_valid = 1'b0;
   logic          s_cmd_ready;
   logic          s_cmd_op = 1'b0;
   logic [AS-1:0] s_cmd_addr = '0;
   logic          s_wvalid = 1'b0;
   logic          s_wready;
   logic [WS-1:0] s_wdata = '0;
   logic          m_rvalid;
   logic          m_rready = 1'b0;
   logic [WS-1:0] m_rdata;
   logic          m_rlast;
   logic          core_wen;
   logic [AS-1:0] core_waddr;
   logic [LW-1:0] core_wdata;
   logic [AS-1:0] core_raddr;
   logic [LW-1:0] core_rdata;
   logic          core_busy = 1'b0;

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   int rd_sample_cyc = -1;

   logic [LW-1:0] mem [256];

   logic [AS-1:0] exp_w_addr [$];
   logic [LW-1:0] exp_w_data [$];
   logic [WS-1:0] exp_rd_data [$];
   logic          exp_rd_last [$];
   logic [AS-1:0] obs_w_addr [$];
   logic [LW-1:0] obs_w_data [$];
   int            obs_w_cyc [$];
   logic [WS-1:0] obs_rd_data [$];
   logic          obs_rd_last [$];
   int            obs_rd_cyc [$];

   core_ram_io_seq #(
      .WORD_SIZE(WS), .NUM_LANES(NL), .ADDR_SIZE(AS), .READ_LATENCY(RL)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .s_cmd_valid(s_cmd_valid), .s_cmd_ready(s_cmd_ready),
      .s_cmd_op(s_cmd_op), .s_cmd_addr(s_cmd_addr),
      .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata),
      .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rdata(m_rdata), .m_rlast(m_rlast),
      .core_wen(core_wen), .core_waddr(core_waddr), .core_wdata(core_wdata),
      .core_raddr(core_raddr), .core_rdata(core_rdata), .core_busy(core_busy)
   );

   always #5 clk = ~clk;

   // RAM model: read data is only meaningful in the one cycle the sequencer
   // is supposed to sample it; any other cycle shows a junk pattern.
   assign core_rdata = (cyc == rd_sample_cyc) ? mem[core_raddr] : JUNK;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (core_wen) mem[core_waddr] <= core_wdata;
   end

   always @(negedge clk) begin
      if (core_wen) begin
         obs_w_addr.push_back(core_waddr);
         obs_w_data.push_back(core_wdata);
         obs_w_cyc.push_back(cyc);
      end
      if (m_rvalid && m_rready) begin
         obs_rd_data.push_back(m_rdata);
         obs_rd_last.push_back(m_rlast);
         obs_rd_cyc.push_back(cyc);
      end
      if (s_cmd_valid && s_cmd_ready && s_cmd_op) rd_sample_cyc = cyc + RL + 1;
   end

   function automatic logic [LW-1:0] make_line(input logic [WS-1:0] base);
      logic [LW-1:0] l;
      for (int i = 0; i < NL; i++) l[i*WS +: WS] = base + WS'(i);
      return l;
   endfunction

   task automatic push_exp_read(input logic [WS-1:0] base);
      for (int i = 0; i < NL; i++) begin
         exp_rd_data.push_back(base + WS'(i));
         exp_rd_last.push_back(i == NL - 1);
      end
   endtask

   task automatic clear_queues();
      exp_w_addr.delete(); exp_w_data.delete();
      exp_rd_data.delete(); exp_rd_last.delete();
      obs_w_addr.delete(); obs_w_data.delete(); obs_w_cyc.delete();
      obs_rd_data.delete(); obs_rd_last.delete(); obs_rd_cyc.delete();
   endtask

   task automatic tick();
      @(posedge clk); #1;
   endtask

   // Called at posedge+1; returns at posedge+1 of the cycle after acceptance.
   task automatic send_cmd(input logic op, input logic [AS-1:0] addr, output int acc);
      int n;
      n = 0;
      s_cmd_valid = 1'b1; s_cmd_op = op; s_cmd_addr = addr;
      #1;
      while (!s_cmd_ready && n < 200) begin @(posedge clk); #2; n++; end
      acc = cyc;
      if (n >= 200) begin
         errors++; checks++;
         $display("FAIL cmd_timeout: s_cmd_ready=0 after 200 cycles, required 1");
         acc = -1;
      end
      @(posedge clk); #1;
      s_cmd_valid = 1'b0;
   endtask

   task automatic send_words(input logic [WS-1:0] base, input int count, input bit gap);
      for (int i = 0; i < count; i++) begin
         int n;
         n = 0;
         s_wvalid = 1'b1; s_wdata = base + WS'(i);
         #1;
         while (!s_wready && n < 50) begin @(posedge clk); #2; n++; end
         if (n >= 50) begin
            errors++; checks++;
            $display("FAIL wdata_timeout lane %0d: s_wready=0, required 1", i);
         end
         @(posedge clk); #1;
         s_wvalid = 1'b0;
         if (gap) begin @(posedge clk); #1; end
      end
   endtask

   task automatic wait_obs(input int nw, input int nr, input int max_cyc);
      for (int k = 0; k < max_cyc; k++) begin
         if (obs_w_addr.size() >= nw && obs_rd_data.size() >= nr) break;
         tick();
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      checks++;
      if ({s_cmd_ready, s_wready, m_rvalid, m_rlast, core_wen} !== 5'b0) begin
         errors++;
         $display("FAIL reset_ctrl: got rdy/wrdy/rvalid/rlast/wen=%b required 00000",
                  {s_cmd_ready, s_wready, m_rvalid, m_rlast, core_wen});
      end
      checks++;
      if ({m_rdata, core_waddr, core_raddr} !== '0 || core_wdata !== '0) begin
         errors++;
         $display("FAIL reset_data: got rdata=%h waddr=%h raddr=%h wdata=%h required all 0",
                  m_rdata, core_waddr, core_raddr, core_wdata);
      end
      rst_n = 1'b1;
      #1;
      checks++;
      if (s_cmd_ready !== 1'b0) begin
         errors++; $display("FAIL reset_release_early: s_cmd_ready=%b required 0", s_cmd_ready);
      end
      @(posedge clk); #2;
      checks++;
      if (s_cmd_ready !== 1'b1) begin
         errors++; $display("FAIL reset_release: s_cmd_ready=%b required 1", s_cmd_ready);
      end
   endtask

   task automatic test_write_read();
      int t;
      logic [WS-1:0] d;
      logic l;
      int c;
      clear_queues();
      m_rready = 1'b1;
      // a word offered while idle must not be taken
      s_wvalid = 1'b1; s_wdata = 16'hFFFF;
      #1;
      checks++;
      if (s_wready !== 1'b0) begin
         errors++; $display("FAIL wready_idle: s_wready=%b required 0", s_wready);
      end
      s_wvalid = 1'b0;
      exp_w_addr.push_back(8'h05);
      exp_w_data.push_back(make_line(16'h1000));
      send_cmd(1'b0, 8'h05, t);
      send_words(16'h1000, NL, 1'b0);
      #1;
      checks++;
      if (core_wen !== 1'b1 || s_cmd_ready !== 1'b0) begin
         errors++;
         $display("FAIL write_cycle: wen=%b cmd_ready=%b required 1/0", core_wen, s_cmd_ready);
      end
      wait_obs(1, 0, 40);
      checks++;
      if (obs_w_addr.size() == 0) begin
         errors++; $display("FAIL wr_b2b: no core_wen pulse seen, required 1");
      end else begin
         c = obs_w_cyc.pop_front();
         if (obs_w_addr.pop_front() !== exp_w_addr.pop_front() ||
             obs_w_data.pop_front() !== exp_w_data.pop_front() || c !== t + NL + 1) begin
            errors++;
            $display("FAIL wr_b2b: addr/data/cycle wrong, wen at cycle %0d required %0d", c, t + NL + 1);
         end
      end
      // read back the same line; command should be accepted right after WRITE
      push_exp_read(16'h1000);
      c = t;
      send_cmd(1'b1, 8'h05, t);
      checks++;
      if (t !== c + NL + 2) begin
         errors++; $display("FAIL next_cmd: accepted at %0d required %0d", t, c + NL + 2);
      end
      wait_obs(0, NL, 80);
      tick(); tick(); tick();
      checks++;
      if (obs_w_addr.size() != 0 || obs_rd_data.size() != NL) begin
         errors++;
         $display("FAIL rd_count: got %0d words %0d writes required %0d words 0 writes",
                  obs_rd_data.size(), obs_w_addr.size(), NL);
      end
      for (int i = 0; i < NL && obs_rd_data.size() > 0; i++) begin
         d = obs_rd_data.pop_front(); l = obs_rd_last.pop_front(); c = obs_rd_cyc.pop_front();
         checks++;
         if (d !== exp_rd_data.pop_front() || l !== exp_rd_last.pop_front()) begin
            errors++;
            $display("FAIL rd_word lane %0d: got data=%h last=%b required data=%h last=%b",
                     i, d, l, 16'h1000 + WS'(i), (i == NL - 1));
         end
         if (i == 0) begin
            checks++;
            if (c !== t + RL + 2) begin
               errors++; $display("FAIL rd_first_cycle: got %0d required %0d", c, t + RL + 2);
            end
         end
         if (i == NL - 1) begin
            checks++;
            if (c !== t + RL + NL + 1) begin
               errors++; $display("FAIL rd_last_cycle: got %0d required %0d", c, t + RL + NL + 1);
            end
         end
      end
   endtask

   task automatic test_write_gaps();
      int t;
      int c;
      clear_queues();
      exp_w_addr.push_back(8'h06);
      exp_w_data.push_back(make_line(16'h1000));
      send_cmd(1'b0, 8'h06, t);
      send_words(16'h1000, NL, 1'b1);
      wait_obs(1, 0, 40);
      checks++;
      if (obs_w_addr.size() == 0) begin
         errors++; $display("FAIL wr_gaps: no core_wen pulse seen, required 1");
      end else begin
         c = obs_w_cyc.pop_front();
         if (obs_w_addr.pop_front() !== exp_w_addr.pop_front() ||
             obs_w_data.pop_front() !== exp_w_data.pop_front() || c !== t + 2 * NL) begin
            errors++;
            $display("FAIL wr_gaps: addr/data/cycle wrong, wen at cycle %0d required %0d", c, t + 2 * NL);
         end
      end
      tick(); tick();
      checks++;
      if (obs_w_addr.size() != 0) begin
         errors++; $display("FAIL wr_gaps_pulse: %0d extra core_wen cycles, required 0", obs_w_addr.size());
      end
   endtask

   task automatic test_read_backpressure();
      int t;
      logic [WS-1:0] d;
      logic l;
      clear_queues();
      push_exp_read(16'h1000);
      m_rready = 1'b1;
      send_cmd(1'b1, 8'h05, t);
      for (int k = 0; k < 60 && obs_rd_data.size() < NL; k++) begin
         m_rready = !(cyc >= t + RL + 9 && cyc <= t + RL + 11);
         #1;
         if (!m_rready) begin
            checks++;
            if (m_rvalid !== 1'b1 || m_rdata !== 16'h1007 || m_rlast !== 1'b0) begin
               errors++;
               $display("FAIL bp_hold: got valid=%b data=%h last=%b required 1/1007/0",
                        m_rvalid, m_rdata, m_rlast);
            end
         end
         @(posedge clk); #1;
      end
      m_rready = 1'b1;
      tick(); tick();
      checks++;
      if (obs_rd_data.size() != NL) begin
         errors++; $display("FAIL bp_count: got %0d words required %0d", obs_rd_data.size(), NL);
      end
      for (int i = 0; i < NL && obs_rd_data.size() > 0; i++) begin
         d = obs_rd_data.pop_front(); l = obs_rd_last.pop_front();
         checks++;
         if (d !== exp_rd_data.pop_front() || l !== exp_rd_last.pop_front()) begin
            errors++;
            $display("FAIL bp_word lane %0d: got data=%h last=%b required data=%h",
                     i, d, l, 16'h1000 + WS'(i));
         end
      end
   endtask

   task automatic test_reset_mid_fill();
      int t;
      int c;
      logic [WS-1:0] d;
      logic l;
      clear_queues();
      send_cmd(1'b0, 8'h02, t);
      send_words(16'h5500, 10, 1'b0);
      rst_n = 1'b0;
      @(posedge clk); #2;
      checks++;
      if ({s_cmd_ready, s_wready, m_rvalid, m_rlast, core_wen} !== 5'b0 ||
          {m_rdata, core_waddr, core_raddr} !== '0 || core_wdata !== '0) begin
         errors++;
         $display("FAIL midfill_reset: got ctrl=%b waddr=%h raddr=%h wdata=%h required all 0",
                  {s_cmd_ready, s_wready, m_rvalid, m_rlast, core_wen}, core_waddr, core_raddr, core_wdata);
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      tick(); tick(); tick();
      checks++;
      if (obs_w_addr.size() != 0) begin
         errors++; $display("FAIL midfill_nowen: %0d core_wen pulses, required 0", obs_w_addr.size());
      end
      obs_w_addr.delete(); obs_w_data.delete(); obs_w_cyc.delete();
      exp_w_addr.push_back(8'h02);
      exp_w_data.push_back(make_line(16'h2000));
      send_cmd(1'b0, 8'h02, t);
      send_words(16'h2000, NL, 1'b0);
      wait_obs(1, 0, 40);
      checks++;
      if (obs_w_addr.size() == 0) begin
         errors++; $display("FAIL midfill_rewrite: no core_wen pulse seen, required 1");
      end else begin
         c = obs_w_cyc.pop_front();
         if (obs_w_addr.pop_front() !== exp_w_addr.pop_front() ||
             obs_w_data.pop_front() !== exp_w_data.pop_front() || c !== t + NL + 1) begin
            errors++;
            $display("FAIL midfill_rewrite: addr/data/cycle wrong, wen at %0d required %0d", c, t + NL + 1);
         end
      end
      push_exp_read(16'h2000);
      m_rready = 1'b1;
      send_cmd(1'b1, 8'h02, t);
      wait_obs(0, NL, 80);
      for (int i = 0; i < NL; i++) begin
         checks++;
         if (obs_rd_data.size() == 0) begin
            errors++; $display("FAIL midfill_read lane %0d: no word, required %h", i, 16'h2000 + WS'(i));
            break;
         end
         d = obs_rd_data.pop_front(); l = obs_rd_last.pop_front();
         if (d !== exp_rd_data.pop_front() || l !== exp_rd_last.pop_front()) begin
            errors++;
            $display("FAIL midfill_read lane %0d: got data=%h last=%b required %h", i, d, l, 16'h2000 + WS'(i));
         end
      end
   endtask

   task automatic test_cmd_during_drain();
      int t1;
      int t2;
      logic [WS-1:0] d;
      logic l;
      clear_queues();
      push_exp_read(16'h1000);
      push_exp_read(16'h2000);
      m_rready = 1'b1;
      send_cmd(1'b1, 8'h05, t1);
      send_cmd(1'b1, 8'h02, t2);
      checks++;
      if (t2 !== t1 + RL + NL + 2) begin
         errors++; $display("FAIL drain_cmd: accepted at %0d required %0d", t2, t1 + RL + NL + 2);
      end
      wait_obs(0, 2 * NL, 80);
      tick(); tick();
      checks++;
      if (obs_rd_data.size() != 2 * NL) begin
         errors++; $display("FAIL drain_count: got %0d words required %0d", obs_rd_data.size(), 2 * NL);
      end
      for (int i = 0; i < 2 * NL && obs_rd_data.size() > 0; i++) begin
         d = obs_rd_data.pop_front(); l = obs_rd_last.pop_front();
         checks++;
         if (d !== exp_rd_data.pop_front() || l !== exp_rd_last.pop_front()) begin
            errors++; $display("FAIL drain_word %0d: got data=%h last=%b", i, d, l);
         end
      end
   endtask

   task automatic test_busy();
`ifdef CORE_RAM_IO_BUSY_GUARD_EN
      int t;
      int c;
      clear_queues();
      core_busy = 1'b1;
      #1;
      checks++;
      if (s_cmd_ready !== 1'b0) begin
         errors++; $display("FAIL busy_ready: s_cmd_ready=%b required 0", s_cmd_ready);
      end
      tick();
      core_busy = 1'b0;
      exp_w_addr.push_back(8'h07);
      exp_w_data.push_back(make_line(16'h3000));
      send_cmd(1'b0, 8'h07, t);
      send_words(16'h3000, NL, 1'b0);
      core_busy = 1'b1;
      #1;
      checks++;
      if (core_wen !== 1'b0) begin
         errors++; $display("FAIL busy_wen_hold: core_wen=%b required 0", core_wen);
      end
      tick(); tick(); tick();
      core_busy = 1'b0;
      wait_obs(1, 0, 20);
      checks++;
      if (obs_w_addr.size() == 0) begin
         errors++; $display("FAIL busy_write: no core_wen pulse seen, required 1");
      end else begin
         c = obs_w_cyc.pop_front();
         if (obs_w_addr.pop_front() !== exp_w_addr.pop_front() ||
             obs_w_data.pop_front() !== exp_w_data.pop_front() || c !== t + NL + 4) begin
            errors++;
            $display("FAIL busy_write: addr/data/cycle wrong, wen at %0d required %0d", c, t + NL + 4);
         end
      end
`else
      core_busy = 1'b1;
      #1;
      checks++;
      if (s_cmd_ready !== 1'b1) begin
         errors++; $display("FAIL busy_ignored: s_cmd_ready=%b required 1", s_cmd_ready);
      end
      tick();
      core_busy = 1'b0;
`endif
   endtask

   initial begin
      test_reset();
      test_write_read();
      test_write_gaps();
      test_read_backpressure();
      test_reset_mid_fill();
      test_cmd_during_drain();
      test_busy();
      tick();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish within 200000 time units");
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire

// File: doc/core_ram_io_seq.md
# core_ram_io_seq

Parametrised host-side load/readback sequencer for the pairing core's wide operand RAM. Host words arrive one per cycle over a valid/ready stream and are packed into one `NUM_LANES`-word line, then written to a chosen RAM address in a single cycle. A read command fetches one line from the core after a fixed read latency and streams it back word by word with a last flag. It sits between the host/test interface and the core's `I_WADDR`/`I_RADDR`/`I_WDATA*`/`result*` ports. It replaces hand-sequenced per-lane loading.

## Interface
- `WORD_SIZE`, 16, bits per lane word.
- `NUM_LANES`, 24, words per RAM line (Fp24 element = 24).
- `ADDR_SIZE`, 8, core RAM address width.
- `READ_LATENCY`, 2, cycles from `core_raddr` valid to `core_rdata` valid; must be ≥1.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `s_cmd_valid` in 1 / `s_cmd_ready` out 1: command handshake.
- `s_cmd_op` in 1: 0 = write line, 1 = read line.
- `s_cmd_addr` in `ADDR_SIZE`: target line address.
- `s_wvalid` in 1 / `s_wready` out 1 / `s_wdata` in `WORD_SIZE`: write word stream, lane 0 first.
- `m_rvalid` out 1 / `m_rready` in 1 / `m_rdata` out `WORD_SIZE` / `m_rlast` out 1: readback stream, lane 0 first.
- `core_wen` out 1, `core_waddr` out `ADDR_SIZE`, `core_wdata` out `NUM_LANES*WORD_SIZE`: core RAM write port.
- `core_raddr` out `ADDR_SIZE`, `core_rdata` in `NUM_LANES*WORD_SIZE`: core RAM read port.
- `core_busy` in 1: core computation in progress.

## Operation
- Lane i maps to bits `[i*WORD_SIZE +: WORD_SIZE]` of `core_wdata` and `core_rdata`.
- FSM states: IDLE, FILL, WRITE, RWAIT, DRAIN. Lane counter width is `$clog2(NUM_LANES)`. Wait counter width is `$clog2(READ_LATENCY+1)`.
- IDLE:
  - `s_cmd_ready`=1.
  - On handshake, latch `s_cmd_addr`.
  - op 0 → FILL with lane counter 0.
  - op 1 → RWAIT, with `core_raddr` loaded and wait counter cleared.
- FILL:
  - `s_wready`=1.
  - Each accepted word is stored in `lane[cnt]` and `cnt` increments.
  - Acceptance of lane `NUM_LANES-1` → WRITE.
  - Gaps in `s_wvalid` stall without penalty.
- WRITE: `core_wen`=1 for exactly one cycle, `core_waddr` = latched address, `core_wdata` = packed buffer → IDLE.
- RWAIT:
  - `core_raddr` is held.
  - Wait counter increments each cycle.
  - When it reaches `READ_LATENCY`, `core_rdata` is captured into the buffer, `cnt`=0 → DRAIN.
- DRAIN:
  - `m_rvalid`=1, `m_rdata`=`lane[cnt]`, `m_rlast` = (`cnt`==`NUM_LANES-1`).
  - On `m_rready`, `cnt` increments.
  - Handshake on the last lane → IDLE.
  - `m_rdata` and `m_rlast` stay stable while `m_rvalid` is high and `m_rready` is low.
- `s_wready` is 0 outside FILL; words offered then are not consumed. `s_cmd_ready` is 0 outside IDLE.
- `core_waddr` and `core_raddr` are registers that hold their last value between operations.

## Timing
- Reset (`rst_n`=0 at a rising edge):
  - state goes to IDLE.
  - all outputs go to 0: `s_cmd_ready`, `s_wready`, `m_rvalid`, `m_rlast`, `m_rdata`, `core_wen`, `core_waddr`, `core_raddr`, `core_wdata`.
  - Buffer and counters are cleared.
  - `s_cmd_ready` rises the first cycle after reset is released.
- Write:
  - Command accepted in cycle T with words back-to-back in T+1..T+`NUM_LANES`.
  - `core_wen` is high in cycle T+`NUM_LANES`+1.
  - Next command can be accepted in T+`NUM_LANES`+2.
- Read:
  - Command accepted in T; `core_raddr` is valid from T+1.
  - `core_rdata` is sampled at the end of cycle T+`READ_LATENCY`+1.
  - `m_rvalid` rises in T+`READ_LATENCY`+2.
  - With `m_rready` held high, `m_rlast` is in T+`READ_LATENCY`+`NUM_LANES`+1.
- Reset mid-operation aborts immediately:
  - a partial FILL buffer is discarded and no `core_wen` is issued.
  - a DRAIN is truncated.
- `core_rdata` changes outside the sample cycle are ignored.

## Configuration
- `CORE_RAM_IO_BUSY_GUARD_EN` defined:
  - `s_cmd_ready` = IDLE and `!core_busy`.
  - The WRITE state stalls with `core_wen`=0 until `core_busy` is low, then issues the write.
- Undefined: `core_busy` is ignored. The port remains present.

## Test plan
- Write then read, `NUM_LANES`=24, `WORD_SIZE`=16, `READ_LATENCY`=2:
  - Write addr 0x05 with words 0x1000+i → one `core_wen` pulse, `core_wdata` lane i = 0x1000+i.
  - Read 0x05 with a RAM model → `m_rdata` 0x1000..0x1017 in order, `m_rlast` only on 0x1017, first `m_rvalid` 4 cycles after the command.
- Write stream gaps: `s_wvalid` toggled every other cycle → `core_wen` exactly 48 cycles after the command, data identical to the back-to-back case.
- Read backpressure: `m_rready` low for 3 cycles on lane 7 → `m_rdata`=lane 7 held stable, no word lost or duplicated, 24 words total.
- Reset mid-FILL: `rst_n` low after 10 of 24 words → no `core_wen`, all outputs 0. A following 24-word write to 0x02 stores only new data.
- Command during DRAIN: `s_cmd_valid` high with `s_cmd_ready`=0 → command accepted only in the cycle after `m_rlast` handshake.
- With `CORE_RAM_IO_BUSY_GUARD_EN`: `core_busy`=1 → `s_cmd_ready`=0. Busy asserted while in WRITE → `core_wen` delayed until the cycle busy falls.
